// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one serial signed divider among NREQ requesters.
// Operands are latched at grant; divide-by-zero bypasses the divider; a stuck divider times out.
module div_arbiter #(
    parameter int N       = 32,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 63
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] req_x,
    input  logic [NREQ*N-1:0] req_y,
    output logic [NREQ-1:0]   ack,
    output logic [N-1:0]      res,
    output logic [N-1:0]      high,
    output logic              dz,
    output logic              tmo,
    output logic              busy,
    output logic [N-1:0]      div_x,
    output logic [N-1:0]      div_y,
    output logic              div_start,
    input  logic [N-1:0]      div_res,
    input  logic [N-1:0]      div_high,
    input  logic              div_finished
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t            state_r, state_s;
    logic [GW-1:0]     ptr_r, ptr_s, gnt_r, gnt_s, pick_s;
    logic [CW-1:0]     cnt_r, cnt_s;
    logic [NREQ-1:0]   ack_r, ack_s;
    logic [N-1:0]      res_r, res_s, high_r, high_s;
    logic [N-1:0]      div_x_r, div_x_s, div_y_r, div_y_s;
    logic [N-1:0]      x_pick_s, y_pick_s;
    logic              dz_r, dz_s, tmo_r, tmo_s, busy_r, busy_s;
    logic              div_start_r, div_start_s, found_s;

    function automatic logic [NREQ-1:0] onehot(input logic [GW-1:0] g);
        onehot = {{(NREQ-1){1'b0}}, 1'b1} << g;
    endfunction

    // Round-robin pick: scanning from the top down lets the lowest offset from ptr win.
    always_comb begin
        pick_s  = ptr_r;
        found_s = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pick_s  = req[(int'(ptr_r) + k) % NREQ] ? GW'((int'(ptr_r) + k) % NREQ) : pick_s;
            found_s = found_s | req[(int'(ptr_r) + k) % NREQ];
        end
        x_pick_s = req_x[int'(pick_s) * N +: N];
        y_pick_s = req_y[int'(pick_s) * N +: N];
    end

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        gnt_s       = gnt_r;
        cnt_s       = cnt_r;
        ack_s       = {NREQ{1'b0}};
        res_s       = res_r;
        high_s      = high_r;
        dz_s        = dz_r;
        tmo_s       = tmo_r;
        div_start_s = 1'b0;
        div_x_s     = div_x_r;
        div_y_s     = div_y_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    gnt_s   = pick_s;
                    div_x_s = x_pick_s;
                    div_y_s = y_pick_s;
                    if (y_pick_s == {N{1'b0}}) begin
                        res_s   = {N{1'b0}};
                        high_s  = x_pick_s;
                        dz_s    = 1'b1;
                        tmo_s   = 1'b0;
                        ack_s   = onehot(pick_s);
                        state_s = DONE;
                    end else begin
                        div_start_s = 1'b1;
                        state_s     = START;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                cnt_s   = {CW{1'b0}};
                state_s = WAIT;
            end
            WAIT: begin
                // div_x/div_y are left untouched: the divider reads operand signs at completion.
                if (div_finished) begin
                    res_s   = div_res;
                    high_s  = div_high;
                    dz_s    = 1'b0;
                    tmo_s   = 1'b0;
                    ack_s   = onehot(gnt_r);
                    state_s = DONE;
                end else begin
                    cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_s == CW'(TIMEOUT)) begin
                        res_s   = {N{1'b0}};
                        high_s  = {N{1'b0}};
                        dz_s    = 1'b0;
                        tmo_s   = 1'b1;
                        ack_s   = onehot(gnt_r);
                        state_s = DONE;
                    end else begin
                        state_s = WAIT;
                    end
                end
            end
            DONE: begin
                if (gnt_r == GW'(NREQ - 1)) begin
                    ptr_s = {GW{1'b0}};
                end else begin
                    ptr_s = gnt_r + {{(GW-1){1'b0}}, 1'b1};
                end
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and registered outputs; reset does not touch the divider itself.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= IDLE;
            ptr_r       <= {GW{1'b0}};
            gnt_r       <= {GW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            ack_r       <= {NREQ{1'b0}};
            res_r       <= {N{1'b0}};
            high_r      <= {N{1'b0}};
            dz_r        <= 1'b0;
            tmo_r       <= 1'b0;
            busy_r      <= 1'b0;
            div_start_r <= 1'b0;
            div_x_r     <= {N{1'b0}};
            div_y_r     <= {N{1'b0}};
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            gnt_r       <= gnt_s;
            cnt_r       <= cnt_s;
            ack_r       <= ack_s;
            res_r       <= res_s;
            high_r      <= high_s;
            dz_r        <= dz_s;
            tmo_r       <= tmo_s;
            busy_r      <= busy_s;
            div_start_r <= div_start_s;
            div_x_r     <= div_x_s;
            div_y_r     <= div_y_s;
        end
    end

    assign ack       = ack_r;
    assign res       = res_r;
    assign high      = high_r;
    assign dz        = dz_r;
    assign tmo       = tmo_r;
    assign busy      = busy_r;
    assign div_start = div_start_r;
    assign div_x     = div_x_r;
    assign div_y     = div_y_r;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural serial divider that finishes
// N edges after its start edge (or never, when dead is set).
module tb_div_arbiter;

    localparam int N    = 32;
    localparam int NREQ = 2;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] req_x, req_y;
    logic [NREQ-1:0]   ack;
    logic [N-1:0]      res, high, div_x, div_y;
    logic              dz, tmo, busy, div_start;
    logic [N-1:0]      div_res = 32'd0;
    logic [N-1:0]      div_high = 32'd0;
    logic              div_finished = 1'b0;
    logic              dead = 1'b0;
    int                dcnt = 0;
    int                starts = 0;
    int                acks = 0;
    int                checks = 0;
    int                fails = 0;
    int                n, st0, bz0, s_before, a_before;

    div_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(63)) dut (
        .CLK(CLK), .RST_N(RST_N), .req(req), .req_x(req_x), .req_y(req_y),
        .ack(ack), .res(res), .high(high), .dz(dz), .tmo(tmo), .busy(busy),
        .div_x(div_x), .div_y(div_y), .div_start(div_start),
        .div_res(div_res), .div_high(div_high), .div_finished(div_finished)
    );

    always #5 CLK = ~CLK;

    // Divider stand-in: restarts on every start pulse, computes at completion.
    always @(posedge CLK) begin
        div_finished <= 1'b0;
        if (div_start) begin
            dcnt <= N;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1 && !dead) begin
                div_finished <= 1'b1;
                div_res      <= $signed(div_x) / $signed(div_y);
                div_high     <= $signed(div_x) % $signed(div_y);
            end
        end
    end

    always @(posedge CLK) begin
        if (div_start) starts <= starts + 1;
        if (|ack) acks <= acks + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Grant edge E0, then count edges until ack is seen (bounded).
    task automatic grant_wait(output int cyc, output int s0, output int b0);
        @(posedge CLK); #1;
        s0 = int'(div_start);
        b0 = int'(busy);
        cyc = 0;
        while (ack == 2'b00 && cyc < 200) begin
            @(posedge CLK); #1;
            cyc++;
        end
    endtask

    task automatic tick(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        RST_N = 1'b1; req = 2'b00; req_x = '0; req_y = '0;
        #1 RST_N = 1'b0;
        #2;
        check("rst_ack", ack, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_start", div_start, 1'b0);
        check("rst_res", res, 32'd0);
        check("rst_divx", div_x, 32'd0);
        #9 RST_N = 1'b1;
        tick(2);

        // Req0 100/7
        req = 2'b01; req_x[31:0] = 32'd100; req_y[31:0] = 32'd7;
        grant_wait(n, st0, bz0);
        check("t1_start", st0, 1);
        check("t1_busy", bz0, 1);
        check("t1_lat", n, 34);
        check("t1_ack", ack, 2'b01);
        check("t1_res", res, 32'd14);
        check("t1_high", high, 32'd2);
        check("t1_flags", {dz, tmo}, 2'b00);
        req = 2'b00;
        tick(1);
        check("t1_ackfall", ack, 2'b00);
        check("t1_idle", busy, 1'b0);

        // Req0 55/0: bypass
        s_before = starts;
        req = 2'b01; req_x[31:0] = 32'd55; req_y[31:0] = 32'd0;
        grant_wait(n, st0, bz0);
        check("dz_lat", n, 0);
        check("dz_ack", ack, 2'b01);
        check("dz_res", res, 32'd0);
        check("dz_high", high, 32'd55);
        check("dz_flags", {dz, tmo}, 2'b10);
        req = 2'b00;
        tick(1);
        check("dz_nostart", starts, s_before);
        check("dz_ackfall", ack, 2'b00);

        // Req1 signed cases
        req = 2'b10; req_x[63:32] = 32'hFFFF_FF9C; req_y[63:32] = 32'd7;
        grant_wait(n, st0, bz0);
        check("t2a_ack", ack, 2'b10);
        check("t2a_res", res, 32'hFFFF_FFF2);
        check("t2a_high", high, 32'hFFFF_FFFE);
        req = 2'b00;
        tick(1);
        req = 2'b10; req_x[63:32] = 32'd100; req_y[63:32] = 32'hFFFF_FFF9;
        grant_wait(n, st0, bz0);
        check("t2b_ack", ack, 2'b10);
        check("t2b_res", res, 32'hFFFF_FFF2);
        check("t2b_high", high, 32'd2);
        req = 2'b00;
        tick(1);

        // Both requesting continuously; operands of req0 changed after its first grant
        req = 2'b11;
        req_x[31:0] = 32'd1000; req_y[31:0] = 32'd3;
        req_x[63:32] = 32'hFFFF_FFCE; req_y[63:32] = 32'd8;
        grant_wait(n, st0, bz0);
        check("rr1_ack", ack, 2'b01);
        check("rr1_res", res, 32'd333);
        check("rr1_high", high, 32'd1);
        req_x[31:0] = 32'hFFFF_FFEB; req_y[31:0] = 32'd4;
        tick(1);
        check("rr1_gap", busy, 1'b0);
        grant_wait(n, st0, bz0);
        check("rr2_busy", bz0, 1);
        check("rr2_ack", ack, 2'b10);
        check("rr2_res", res, 32'hFFFF_FFFA);
        check("rr2_high", high, 32'hFFFF_FFFE);
        tick(1);
        check("rr2_gap", busy, 1'b0);
        grant_wait(n, st0, bz0);
        check("rr3_ack", ack, 2'b01);
        check("rr3_res", res, 32'hFFFF_FFFB);
        check("rr3_high", high, 32'hFFFF_FFFF);
        tick(1);
        grant_wait(n, st0, bz0);
        check("rr4_ack", ack, 2'b10);
        check("rr4_lat", n, 34);
        req = 2'b00;
        tick(1);
        check("rr4_idle", busy, 1'b0);

        // Dead divider: timeout, then normal service
        dead = 1'b1;
        req = 2'b01; req_x[31:0] = 32'd7; req_y[31:0] = 32'd1;
        grant_wait(n, st0, bz0);
        check("tmo_lat", n, 64);
        check("tmo_ack", ack, 2'b01);
        check("tmo_res", res, 32'd0);
        check("tmo_flags", {dz, tmo}, 2'b01);
        req = 2'b00;
        dead = 1'b0;
        tick(1);
        req = 2'b10; req_x[63:32] = 32'd9; req_y[63:32] = 32'd2;
        grant_wait(n, st0, bz0);
        check("post_lat", n, 34);
        check("post_ack", ack, 2'b10);
        check("post_res", res, 32'd4);
        check("post_flags", {dz, tmo}, 2'b00);
        req = 2'b00;
        tick(1);

        // Reset mid-WAIT; stale finished must be ignored afterwards
        req = 2'b01; req_x[31:0] = 32'd77; req_y[31:0] = 32'd5;
        tick(10);
        check("mid_busy", busy, 1'b1);
        RST_N = 1'b0;
        req = 2'b00;
        #1;
        check("ar_busy", busy, 1'b0);
        check("ar_res", res, 32'd0);
        check("ar_divx", div_x, 32'd0);
        check("ar_ack", ack, 2'b00);
        #6 RST_N = 1'b1;
        a_before = acks;
        tick(40);
        check("stale_noack", acks, a_before);
        check("stale_idle", busy, 1'b0);
        req = 2'b01; req_x[31:0] = 32'd1000; req_y[31:0] = 32'd10;
        grant_wait(n, st0, bz0);
        check("rs_lat", n, 34);
        check("rs_ack", ack, 2'b01);
        check("rs_res", res, 32'd100);
        check("rs_high", high, 32'd0);
        req = 2'b00;
        tick(1);
        check("rs_ackfall", ack, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one serial signed divider (`start`/`finished` protocol, results on `res`/`high`) between NREQ requesters, for example the CPU core and a coprocessor.
- Arbitrates round-robin and registers operands at grant.
- Sequences the divider's one-cycle start pulse and waits for its finished pulse.
- Bypasses divide-by-zero and aborts on timeout, returning the result with a one-cycle ack to the granted requester.

Parameters:
- N, 32, operand/result width (must match the divider).
- NREQ, 2, number of requesters (2..8).
- TIMEOUT, 63, maximum cycles spent in WAIT before abort (must exceed N+1).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request level.
- req_x  in  NREQ*N  dividends; requester i uses bits [i*N +: N].
- req_y  in  NREQ*N  divisors, same packing.
- ack  out  NREQ  one-hot, one-cycle completion pulse.
- res  out  N  quotient for the acked requester.
- high  out  N  remainder for the acked requester.
- dz  out  1  divide-by-zero flag, valid while ack is high.
- tmo  out  1  timeout flag, valid while ack is high.
- busy  out  1  high in every state except IDLE.
- div_x  out  N  dividend to divider.
- div_y  out  N  divisor to divider.
- div_start  out  1  divider start pulse.
- div_res  in  N  divider quotient.
- div_high  in  N  divider remainder.
- div_finished  in  1  divider done pulse.

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE, priority pointer=0.
  - ack, res, high, dz, tmo, div_start, div_x, div_y all 0.
  - Timeout counter 0.
  - Takes effect mid-operation with no ack issued; the divider is not reset.
- States: IDLE, START, WAIT, DONE. All outputs are registered.
- IDLE:
  - req is sampled only in this state.
  - Grant the lowest-index asserted req at or above the pointer, wrapping to lower indices.
  - On the grant edge, latch grant index, div_x=req_x[g], div_y=req_y[g].
  - If req_y[g]==0: go to DONE with res=0, high=req_x[g], dz=1, tmo=0, ack[g]=1. The divider is not started.
  - Otherwise go to START with div_start=1.
- START:
  - Exactly one cycle; div_start is high only in this state.
  - Next edge: div_start=0, counter cleared, go to WAIT.
- WAIT:
  - div_x and div_y are held stable, because the divider reads their signs at completion.
  - div_finished is sampled only here; it is ignored in every other state.
  - On div_finished=1: res=div_res, high=div_high, dz=0, tmo=0, ack[g]=1, go to DONE.
  - Otherwise increment the counter. When it reaches TIMEOUT: res=0, high=0, tmo=1, ack[g]=1, go to DONE.
- DONE:
  - ack is high for this one cycle only.
  - Next edge: ack=0, pointer=(g+1) mod NREQ, go to IDLE.
  - res, high, dz and tmo hold until the next completion.
- Timing with the team divider (finished N edges after its start edge):
  - Let the grant edge be E0. ack rises at E(N+2) and falls at E(N+3).
  - The next grant is at E(N+4) at the earliest.
  - Divide-by-zero: ack rises at E0 and falls at E1.
- Requester rule:
  - Hold req until ack is sampled high, then deassert on that edge.
  - req still high in the following IDLE cycle is a new request.
  - Operands are latched at grant, so the requester may change them afterwards.
- Arithmetic: signed two's complement, passed through unchanged. Remainder sign follows the dividend (divider's rule).
- Simultaneous events:
  - A req arriving during busy waits and is not lost.
  - All reqs high at once: served strictly in rotation, so no requester is starved.
  - Stale div_finished while not in WAIT is ignored. A new div_start re-initialises the divider, so a run interrupted by reset cannot corrupt the next operation.

Test Plan:
- Req0: x=100, y=7 → ack[0] exactly at E34 (N=32), res=14, high=2, dz=0, tmo=0, single-cycle ack.
- Req1: x=-100, y=7 → res=-14 (0xFFFFFFF2), high=-2; x=100, y=-7 → res=-14, high=2.
- Req0: x=55, y=0 → ack[0] the cycle after grant, res=0, high=55, dz=1, div_start never asserted.
- req=2'b11 held continuously with distinct operands → grants alternate 0,1,0,1; each ack carries the matching quotient; busy stays high except a single IDLE cycle between operations.
- Stub divider never asserting div_finished → ack with tmo=1, res=0 after TIMEOUT WAIT cycles; next request is then served normally.
- RST_N pulsed low mid-WAIT → outputs 0 immediately, no ack; a subsequent 1000/10 yields res=100, high=0 with correct timing.
